univ_shift_register: RTL and testbench

//  - Parametrised successor to the divider's plain load register. Adds sync clear, parallel load,
//    1-bit shift L/R with serial-in, inc/dec, and a multi-cycle shift-by-N engine with start/busy/done.
//  - Holds the divider's remainder/quotient operands and its iteration shifts.
//  - The divider control FSM issues one command per cycle, or a single start for an N-bit shift.

---
 rtl/univ_shift_register_pkg.sv | 14 +
 rtl/univ_shift_register.sv | 115 +++++++++++
 tb/tb_univ_shift_register.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/univ_shift_register_pkg.sv
// Shared types for the universal shift register: FSM state encoding and
// shift-direction constants used by the divider datapath.
package univ_shift_register_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic SHL_DIR = 1'b0;
  localparam logic SHR_DIR = 1'b1;

endpackage

// File: rtl/univ_shift_register.sv
// Universal shift register: clear, load, 1-bit shifts, inc/dec, and a
// multi-cycle shift-by-N engine with start/busy/done handshaking.
module univ_shift_register
  import univ_shift_register_pkg::*;
#(
  parameter int             WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int            CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             shl,
  input  logic             shr,
  input  logic             inc,
  input  logic             dec,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic             cout_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic             dir_r, dir_n;
  logic [CNT_W-1:0] amt_sat;

  assign amt_sat = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign zero = (q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= RESET_VAL;
      cout  <= 1'b0;
      rem   <= '0;
      dir_r <= SHL_DIR;
    end else begin
      state <= state_n;
      q     <= q_n;
      cout  <= cout_n;
      rem   <= rem_n;
      dir_r <= dir_n;
    end
  end

  // Only IDLE accepts commands; SHIFT and DONE react to clr alone.
  always_comb begin
    state_n = state;
    q_n     = q;
    cout_n  = cout;
    rem_n   = rem;
    dir_n   = dir_r;
    case (state)
      IDLE: begin
        if (clr) begin
          q_n = RESET_VAL;
        end else if (ld) begin
          q_n = d;
        end else if (start) begin
          dir_n   = dir;
          rem_n   = amt_sat;
          state_n = (amt_sat == '0) ? DONE : SHIFT;
        end else if (shl) begin
          q_n    = {q[WIDTH-2:0], sin};
          cout_n = q[WIDTH-1];
        end else if (shr) begin
          q_n    = {sin, q[WIDTH-1:1]};
          cout_n = q[0];
        end else if (inc) begin
          q_n    = q + 1'b1;
          cout_n = (q == '1);
        end else if (dec) begin
          q_n    = q - 1'b1;
          cout_n = (q == '0);
        end
      end
      SHIFT: begin
        if (clr) begin
          q_n     = RESET_VAL;
          rem_n   = '0;
          state_n = IDLE;
        end else begin
          if (dir_r == SHL_DIR) begin
            q_n    = {q[WIDTH-2:0], sin};
            cout_n = q[WIDTH-1];
          end else begin
            q_n    = {sin, q[WIDTH-1:1]};
            cout_n = q[0];
          end
          rem_n = rem - 1'b1;
          if (rem == CNT_W'(1)) state_n = DONE;
        end
      end
      DONE: begin
        if (clr) q_n = RESET_VAL;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_univ_shift_register.sv
// Directed self-checking bench for univ_shift_register at WIDTH=4, RESET_VAL=0.
module tb_univ_shift_register;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst, clr, ld, shl, shr, inc, dec, sin, start, dir;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] q;
  logic             cout, busy, done, zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  univ_shift_register #(.WIDTH(WIDTH), .RESET_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .shl(shl), .shr(shr),
    .inc(inc), .dec(dec), .sin(sin), .start(start), .amt(amt), .dir(dir),
    .q(q), .cout(cout), .busy(busy), .done(done), .zero(zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; clr = 0; ld = 0; shl = 0; shr = 0; inc = 0; dec = 0;
    sin = 0; start = 0; dir = 0; d = '0; amt = '0;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    ld = 1; d = v; tick(); ld = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); rst = 0;
    load(4'hA);
    inc = 1; tick(); inc = 0;
    rst = 1; tick(); rst = 0;
    n_checks++; if (q !== 4'h0) $display("[TB] FAIL rst_q: got %b want 0000", q); else n_pass++;
    n_checks++; if ({cout, busy, done} !== 3'b000) $display("[TB] FAIL rst_flags: got %b want 000", {cout, busy, done}); else n_pass++;
    n_checks++; if (zero !== 1'b1) $display("[TB] FAIL rst_zero: got %b want 1", zero); else n_pass++;
  endtask

  task automatic test_single_shift();
    load(4'b1011);
    shl = 1; sin = 0; tick(); shl = 0;
    n_checks++; if ({q, cout} !== 5'b0110_1) $display("[TB] FAIL shl: got q=%b cout=%b want q=0110 cout=1", q, cout); else n_pass++;
    shr = 1; sin = 1; tick(); shr = 0; sin = 0;
    n_checks++; if ({q, cout} !== 5'b1011_0) $display("[TB] FAIL shr: got q=%b cout=%b want q=1011 cout=0", q, cout); else n_pass++;
  endtask

  task automatic test_inc_dec();
    load(4'hF);
    inc = 1; tick(); inc = 0;
    n_checks++; if ({q, cout, zero} !== 6'b0000_1_1) $display("[TB] FAIL inc_wrap: got q=%b cout=%b zero=%b want 0000 1 1", q, cout, zero); else n_pass++;
    dec = 1; tick(); dec = 0;
    n_checks++; if ({q, cout} !== 5'b1111_1) $display("[TB] FAIL dec_wrap: got q=%b cout=%b want 1111 1", q, cout); else n_pass++;
    load(4'h5);
    inc = 1; tick(); inc = 0;
    n_checks++; if ({q, cout} !== 5'b0110_0) $display("[TB] FAIL inc_plain: got q=%b cout=%b want 0110 0", q, cout); else n_pass++;
    dec = 1; tick(); dec = 0;
    n_checks++; if ({q, cout} !== 5'b0101_0) $display("[TB] FAIL dec_plain: got q=%b cout=%b want 0101 0", q, cout); else n_pass++;
  endtask

  task automatic test_multi_shift();
    logic [WIDTH-1:0] exp_q [3];
    exp_q[0] = 4'b0011; exp_q[1] = 4'b0111; exp_q[2] = 4'b1111;
    load(4'b1001);
    start = 1; amt = 3; dir = 0; sin = 1; tick(); start = 0;
    n_checks++; if ({q, busy, done} !== 6'b1001_1_0) $display("[TB] FAIL ms_start: got q=%b busy=%b done=%b want 1001 1 0", q, busy, done); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin ld = 1; d = 4'b0000; end
      tick();
      ld = 0;
      n_checks++;
      if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2))
        $display("[TB] FAIL ms_step%0d: got q=%b busy=%b done=%b want q=%b busy=%b done=%b",
                 i, q, busy, done, exp_q[i], (i < 2), (i == 2));
      else n_pass++;
    end
    n_checks++; if (cout !== 1'b0) $display("[TB] FAIL ms_cout: got %b want 0", cout); else n_pass++;
    tick();
    n_checks++; if ({busy, done, q} !== 6'b0_0_1111) $display("[TB] FAIL ms_after: got busy=%b done=%b q=%b want 0 0 1111", busy, done, q); else n_pass++;
    sin = 0;
  endtask

  task automatic test_amt_zero();
    load(4'b0110);
    start = 1; amt = 0; tick(); start = 0;
    n_checks++; if ({busy, done, q} !== 6'b0_1_0110) $display("[TB] FAIL amt0_done: got busy=%b done=%b q=%b want 0 1 0110", busy, done, q); else n_pass++;
    tick();
    n_checks++; if ({busy, done, q} !== 6'b0_0_0110) $display("[TB] FAIL amt0_after: got busy=%b done=%b q=%b want 0 0 0110", busy, done, q); else n_pass++;
  endtask

  task automatic test_saturate();
    int busy_cycles = 0;
    bit seen_done = 0;
    load(4'b0000);
    start = 1; amt = 7; dir = 1; sin = 1; tick(); start = 0;
    for (int i = 0; i < 12 && !seen_done; i++) begin
      if (busy) busy_cycles++;
      if (done) seen_done = 1;
      else tick();
    end
    n_checks++; if (!seen_done) $display("[TB] FAIL sat_timeout: got no done want done within 12 cycles"); else n_pass++;
    n_checks++; if (busy_cycles != 4) $display("[TB] FAIL sat_busy: got %0d cycles want 4", busy_cycles); else n_pass++;
    n_checks++; if ({q, cout} !== 5'b1111_0) $display("[TB] FAIL sat_q: got q=%b cout=%b want 1111 0", q, cout); else n_pass++;
    tick(); sin = 0; dir = 0;
  endtask

  task automatic test_priority();
    load(4'b1100);
    ld = 1; d = 4'b0101; start = 1; amt = 2; tick(); ld = 0; start = 0;
    n_checks++; if ({q, busy, done} !== 6'b0101_0_0) $display("[TB] FAIL ld_start: got q=%b busy=%b done=%b want 0101 0 0", q, busy, done); else n_pass++;
    tick();
    n_checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL ld_start_drop: got busy=%b done=%b want 0 0", busy, done); else n_pass++;
    shl = 1; shr = 1; sin = 0; tick(); shl = 0; shr = 0;
    n_checks++; if ({q, cout} !== 5'b1010_0) $display("[TB] FAIL shl_shr: got q=%b cout=%b want 1010 0", q, cout); else n_pass++;
    clr = 1; ld = 1; d = 4'hF; tick(); clr = 0; ld = 0;
    n_checks++; if ({q, zero} !== 5'b0000_1) $display("[TB] FAIL clr_ld: got q=%b zero=%b want 0000 1", q, zero); else n_pass++;
  endtask

  task automatic test_clr_mid_shift();
    load(4'b0001);
    start = 1; amt = 4; dir = 0; sin = 0; tick(); start = 0;
    tick();
    n_checks++; if ({q, busy} !== 5'b0010_1) $display("[TB] FAIL clr_pre: got q=%b busy=%b want 0010 1", q, busy); else n_pass++;
    clr = 1; tick(); clr = 0;
    n_checks++; if ({q, busy, done} !== 6'b0000_0_0) $display("[TB] FAIL clr_mid: got q=%b busy=%b done=%b want 0000 0 0", q, busy, done); else n_pass++;
    tick();
    n_checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL clr_nodone: got busy=%b done=%b want 0 0", busy, done); else n_pass++;
  endtask

  task automatic test_rst_mid_shift();
    load(4'b0011);
    start = 1; amt = 4; dir = 0; sin = 1; tick(); start = 0;
    tick(); tick();
    n_checks++; if ({q, cout, busy} !== 6'b1111_0_1) $display("[TB] FAIL rst_pre: got q=%b cout=%b busy=%b want 1111 0 1", q, cout, busy); else n_pass++;
    tick();
    rst = 1; tick(); rst = 0;
    n_checks++; if ({q, cout, busy, done, zero} !== 8'b0000_0_0_0_1) $display("[TB] FAIL rst_mid: got q=%b cout=%b busy=%b done=%b zero=%b want 0000 0 0 0 1", q, cout, busy, done, zero); else n_pass++;
    tick();
    n_checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL rst_nodone: got busy=%b done=%b want 0 0", busy, done); else n_pass++;
    sin = 0;
  endtask

  initial begin
    test_reset();
    test_single_shift();
    test_inc_dec();
    test_multi_shift();
    test_amt_zero();
    test_saturate();
    test_priority();
    test_clr_mid_shift();
    test_rst_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
